// File: rtl/sub_serial_8bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sub_pkg
// Description : Shared definitions for the bit-serial subtractor: default
//               operand width, controller state encoding and the helper that
//               sizes the bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package sub_pkg;

    // Default operand / result width in bits.
    localparam int c_DEFAULT_WIDTH = 8;

    // Controller states, explicitly two bits wide.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit-counter width: enough to count 0 .. w-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_serial_8bits_bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : sub_bit_cell
// Description : Combinational 1-bit full subtractor, d = a - b - bin.
//               Borrow-side twin of the 1-bit adder cell.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated/propagated by this position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule
`default_nettype wire

// File: rtl/sub_serial_8bits.sv
`default_nettype none
// ============================================================================
// Module      : sub_serial_8bits
// Description : Bit-serial subtractor computing D = A - B - Bin over WIDTH
//               clock cycles, LSB first, using a single full-subtractor cell
//               and a registered borrow. Start/Busy/Done handshake.
//               Optional macro SIGNED_OVF_EN adds the Ovf output (signed
//               two's-complement overflow of the subtraction).
// Revision    : 1.0 - initial release
// ============================================================================
module sub_serial_8bits
    import sub_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             Zero,
    output logic             Less
`ifdef SIGNED_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int              c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [c_CW-1:0]  r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

    // A request is honoured whenever no subtraction is running (IDLE or DONE).
    assign w_accept   = (r_state != RUN) && Start;
    // Final bit position of the running subtraction.
    assign w_last     = (r_state == RUN) && (r_cnt == c_LAST);
    // Result register after shifting in this cycle's difference bit at the MSB.
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    sub_bit_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; DONE re-enters RUN directly for back-to-back requests.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (Start) w_next_state = RUN;
            RUN:     if (w_last) w_next_state = DONE;
            DONE:    w_next_state = Start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        Busy = (r_state == RUN);
        Done = (r_state == DONE);
    end

    // Serial datapath: latch operands on accept, then shift one bit per cycle.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_res <= '0;
            r_br  <= Bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_br  <= w_bout;
            r_cnt <= r_cnt + c_ONE;
        end
    end

    // Visible result is only committed on the last bit, so it never shows
    // a partially shifted value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            D    <= '0;
            Bout <= 1'b0;
            Zero <= 1'b0;
            Less <= 1'b0;
        end else if (w_last) begin
            D    <= w_res_next;
            Bout <= w_bout;
            Zero <= (w_res_next == '0);
            Less <= w_bout;
        end
    end

`ifdef SIGNED_OVF_EN
    logic r_amsb;
    logic r_bmsb;

    // Operand sign bits are kept aside because the shift registers lose them.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
        end else if (w_accept) begin
            r_amsb <= A[WIDTH-1];
            r_bmsb <= B[WIDTH-1];
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from A.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Ovf <= 1'b0;
        end else if (w_last) begin
            Ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_d);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_serial_8bits.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_serial_8bits
// Description : Self-checking bench for sub_serial_8bits: directed cases,
//               back-to-back, ignored Start, mid-run reset, random operands
//               checked against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_serial_8bits;

    localparam int W = 8;

    logic         Clk   = 1'b0;
    logic         Rst   = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Bin   = 1'b0;
    logic         Busy;
    logic         Done;
    logic [W-1:0] D;
    logic         Bout;
    logic         Zero;
    logic         Less;
`ifdef SIGNED_OVF_EN
    logic         Ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Expected visible result (held between Done pulses).
    logic [W-1:0] m_d    = '0;
    logic         m_bout = 1'b0;
    logic         m_zero = 1'b0;
    logic         m_less = 1'b0;
    logic         m_ovf  = 1'b0;

    sub_serial_8bits #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .Busy  (Busy),
        .Done  (Done),
        .D     (D),
        .Bout  (Bout),
        .Zero  (Zero),
        .Less  (Less)
`ifdef SIGNED_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int diff;
        int sa;
        int sb;
        int sr;
        diff   = int'(a) - int'(b) - int'(bin);
        m_d    = W'(diff);
        m_bout = (diff < 0);
        m_less = (diff < 0);
        m_zero = (m_d == '0);
        sa     = (int'(a) >= (1 << (W-1))) ? int'(a) - (1 << W) : int'(a);
        sb     = (int'(b) >= (1 << (W-1))) ? int'(b) - (1 << W) : int'(b);
        sr     = sa - sb - int'(bin);
        m_ovf  = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
    endtask

    task automatic chk_held(input string tag);
        chk(tag, {Busy, Done, D, Bout, Zero, Less}, {1'b1, 1'b0, m_d, m_bout, m_zero, m_less});
`ifdef SIGNED_OVF_EN
        chk({tag, "_ovf"}, Ovf, m_ovf);
`endif
    endtask

    // One subtraction; returns at the negedge inside the Done cycle.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                      input int gap, input bit mid_start);
        for (int g = 0; g < gap; g++) begin
            @(negedge Clk);
            chk("idle", {Busy, Done}, 2'b00);
        end
        A = a; B = b; Bin = bin; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
        for (int k = 0; k < W; k++) begin
            @(negedge Clk);
            if (mid_start && k == 2) begin
                Start = 1'b1; A = 8'h00; B = 8'hFF; Bin = 1'b0;
            end else if (mid_start && k == 3) begin
                Start = 1'b0;
            end
            chk_held("run_hold");
        end
        model(a, b, bin);
        @(negedge Clk);
        chk("done_pulse", {Busy, Done}, 2'b01);
        chk("d", D, m_d);
        chk("flags", {Bout, Zero, Less}, {m_bout, m_zero, m_less});
`ifdef SIGNED_OVF_EN
        chk("ovf", Ovf, m_ovf);
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge Clk);
        chk("reset", {Busy, Done, D, Bout, Zero, Less}, '0);
`ifdef SIGNED_OVF_EN
        chk("reset_ovf", Ovf, 1'b0);
`endif
        Rst = 1'b0;

        // Directed cases
        op(8'h05, 8'h03, 1'b0, 1, 1'b0);
        chk("t1_d", D, 8'h02);
        op(8'h03, 8'h05, 1'b0, 1, 1'b0);
        chk("t2_d", {D, Bout, Less, Zero}, {8'hFE, 1'b1, 1'b1, 1'b0});
        op(8'h40, 8'h3F, 1'b1, 1, 1'b0);
        chk("t3_zero", {D, Zero, Bout}, {8'h00, 1'b1, 1'b0});
        op(8'hFF, 8'h01, 1'b0, 0, 1'b0);          // accepted in DONE cycle
        chk("t3_b2b_d", D, 8'hFE);

        // Start while busy is ignored; exactly one Done (next op checks idle)
        op(8'h20, 8'h05, 1'b0, 1, 1'b1);
        chk("t4_d", D, 8'h1B);
        @(negedge Clk);
        chk("t4_single_done", {Busy, Done}, 2'b00);

        // Asynchronous reset during RUN
        A = 8'h55; B = 8'h11; Bin = 1'b0; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (4) @(negedge Clk);
        #1 Rst = 1'b1;
        #1;
        chk("t5_abort", {Busy, Done, D, Bout, Zero, Less}, '0);
        @(negedge Clk);
        Rst = 1'b0;
        m_d = '0; m_bout = 1'b0; m_zero = 1'b0; m_less = 1'b0; m_ovf = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(negedge Clk);
            chk("t5_no_done", {Busy, Done, D}, '0);
        end
        op(8'h10, 8'h01, 1'b0, 0, 1'b0);
        chk("t5_d", D, 8'h0F);

        // Boundaries
        op(8'h00, 8'hFF, 1'b1, 1, 1'b0);
        chk("bnd_min", {D, Bout, Zero}, {8'h00, 1'b1, 1'b1});
        op(8'hFF, 8'h00, 1'b0, 0, 1'b0);
        chk("bnd_max", {D, Bout}, {8'hFF, 1'b0});

`ifdef SIGNED_OVF_EN
        op(8'h80, 8'h01, 1'b0, 1, 1'b0);
        chk("t6a", {D, Ovf}, {8'h7F, 1'b1});
        op(8'h7F, 8'hFF, 1'b0, 1, 1'b0);
        chk("t6b", {D, Ovf}, {8'h80, 1'b1});
        op(8'h10, 8'h01, 1'b0, 1, 1'b0);
        chk("t6c", Ovf, 1'b0);
`endif

        // Random operands with random idle gaps (including back-to-back)
        for (int r = 0; r < 24; r++) begin
            op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub_serial_8bits.md
Name: sub_serial_8bits

Overview:
- Bit-serial subtractor. It is the inverse-direction companion of the team's 8-bit ripple adder.
- Computes D = A - B - Bin over WIDTH clock cycles, one bit per cycle, LSB first.
- Uses a 1-bit full-subtractor cell and a registered borrow.
- Sits on the datapath where area matters more than latency. It exposes a Start/Busy/Done handshake to the controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled only when Busy=0
- A  in  WIDTH  minuend, latched on accepted Start
- B  in  WIDTH  subtrahend, latched on accepted Start
- Bin  in  1  borrow-in, latched on accepted Start
- Busy  out  1  high while a subtraction is in progress (RUN state)
- Done  out  1  one-cycle pulse when the result becomes valid
- D  out  WIDTH  difference (mod 2^WIDTH)
- Bout  out  1  borrow-out of the MSB
- Zero  out  1  D == 0
- Less  out  1  unsigned A < B + Bin (equals Bout)

Behaviour:
- Interface: one clock (Clk); reset Rst is asynchronous and active-high.
- Reset: state IDLE. Busy, Done, D, Bout, Zero and Less are all 0. Shift registers, borrow register and counter are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: Start=1 -> latch A, B and Bin into shift/borrow registers, clear counter, go to RUN.
  - RUN: each edge does the following.
    - Cell computes d = a^b^br and br' = (~a&b) | (~(a^b)&br) on the current LSBs.
    - d shifts into the result register MSB-side; operands shift right.
    - Counter increments.
    - On the edge where counter == WIDTH-1: D, Bout, Zero and Less are updated, Done is set to 1, and the state goes to DONE.
  - DONE: lasts exactly one cycle. Done=0 on the next edge. Start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: if Start is sampled at edge e0, Done is high after edge e0+WIDTH for one cycle. Busy is high after e0 until e0+WIDTH.
- Start while Busy=1 is ignored. Operands are not re-latched and the result is unaffected.
- A, B and Bin may change freely after the accepting edge.
- D, Bout, Zero and Less hold their last value until the next Done. They are never partially updated during RUN.
- Rst mid-RUN aborts immediately: outputs return to reset values and no Done is produced.
- Width rules:
  - Counter width is clog2(WIDTH).
  - Arithmetic is unsigned modulo 2^WIDTH.
  - Bout=1 exactly when A < B + Bin, treated as unsigned (WIDTH+1)-bit values.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- Defined: adds output port Ovf (out, 1), the signed two's-complement overflow of A - B - Bin.
  - Ovf = (A[MSB]^B[MSB]) & (A[MSB]^D[MSB]), using the latched operands.
  - Ovf is updated with D on the Done edge, held otherwise, and reset to 0.
- Undefined: no Ovf port, and no MSB capture logic.

Decomposition:
- Package sub_pkg holds:
  - the default WIDTH constant;
  - the state typedef enum {IDLE, RUN, DONE};
  - the counter width function/constant.
- One sub-module: sub_bit_cell, a combinational 1-bit full subtractor (inputs a, b, bin; outputs d, bout). It is instantiated once and mirrors the team's 1-bit adder cell.

Test Plan:
1. A=0x05, B=0x03, Bin=0, Start at e0 -> Done only after e8; D=0x02, Bout=0, Zero=0, Less=0; Busy high e1..e8.
2. A=0x03, B=0x05, Bin=0 -> D=0xFE, Bout=1, Less=1, Zero=0.
3. A=0x40, B=0x3F, Bin=1 -> D=0x00, Zero=1, Bout=0. Then, with Start held high in the DONE cycle with A=0xFF, B=0x01 -> second Done 8 edges later with D=0xFE.
4. Start pulsed mid-RUN with A=0x00, B=0xFF -> ignored; result is from the first operands; exactly one Done.
5. Rst asserted asynchronously at cycle 4 of RUN -> Busy, D and Done drop to 0 immediately; no Done appears. Next Start with A=0x10, B=0x01 -> D=0x0F.
6. SIGNED_OVF_EN defined:
   - A=0x80, B=0x01 -> D=0x7F, Ovf=1.
   - A=0x7F, B=0xFF -> D=0x80, Ovf=1.
   - A=0x10, B=0x01 -> Ovf=0.
